// File: rtl/upsample_hold_pkg.sv
// Shared definitions for the upsample_hold stream stage: parameter defaults,
// counter-width helper and the FSM state type.
package upsample_hold_pkg;

  // Default sample width (signed two's complement, passed through untouched).
  localparam int unsigned OW_DEF  = 14;
  // Default repetition factor; legal range 1..1024.
  localparam int unsigned DEC_DEF = 20;

  // Repetition counter width: $clog2(dec) with a floor of one bit so that
  // DEC=1 and DEC=2 still get a usable counter.
  function automatic int unsigned cnt_width(input int unsigned dec);
    return (dec <= 2) ? 1 : $clog2(dec);
  endfunction

  // IDLE: no sample being emitted. RUN: repeating the current sample.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/upsample_hold_buf.sv
// One-entry valid/ready holding register. Accepts a new word in the same cycle
// the held word is unloaded, so a full buffer does not cost a bubble.
// ready_o depends only on the full flag and unload_i, never on valid_i.
module upsample_hold_buf #(
  parameter int unsigned W = 14
) (
  input  logic         clk_i,
  input  logic         rst_n,
  input  logic [W-1:0] data_i,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic         unload_i,
  output logic [W-1:0] data_o,
  output logic         full_o
);

  logic [W-1:0] buf_q;
  logic         full_q;
  logic         accept;

  assign ready_o = !full_q || unload_i;
  assign accept  = valid_i && ready_o;
  assign data_o  = buf_q;
  assign full_o  = full_q;

  // Load on accept (wins over a simultaneous unload, keeping full set);
  // otherwise an unload empties the buffer.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      buf_q  <= '0;
      full_q <= 1'b0;
    end else if (accept) begin
      buf_q  <= data_i;
      full_q <= 1'b1;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

endmodule

// File: rtl/upsample_hold.sv
// upsample_hold: regenerates a full-rate stream from a slow-rate one by
// emitting each accepted sample DEC times. first_o marks the first repetition;
// underflow_o is a sticky flag for a window that ends with nothing buffered.
// Build option UPSAMPLE_HOLD_ZERO_STUFF_EN: zero-stuffing instead of
// zero-order hold (sample on the first repetition only, zero elsewhere).
module upsample_hold
  import upsample_hold_pkg::*;
#(
  parameter int unsigned OW  = OW_DEF,
  parameter int unsigned DEC = DEC_DEF
) (
  input  logic          clk_i,
  input  logic          rst_n,
  input  logic [OW-1:0] data_i,
  input  logic          valid_i,
  output logic          ready_o,
  input  logic          clr_i,
  output logic [OW-1:0] data_o,
  output logic          valid_o,
  output logic          first_o,
  output logic          underflow_o
);

  localparam int unsigned   CW       = cnt_width(DEC);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEC - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [OW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          first_q, first_d;
  logic          under_q, under_d;

  logic [OW-1:0] buf_data;
  logic          buf_full;
  logic          unload;
  logic          win_last;

  upsample_hold_buf #(
    .W (OW)
  ) u_buf (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .data_i   (data_i),
    .valid_i  (valid_i),
    .ready_o  (ready_o),
    .unload_i (unload),
    .data_o   (buf_data),
    .full_o   (buf_full)
  );

  assign win_last = (state_q == RUN) && (cnt_q == CNT_LAST);

  // Next-state and output logic; unload is a function of registers only.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    first_d = 1'b0;
    under_d = clr_i ? 1'b0 : under_q;
    unload  = 1'b0;

    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (buf_full) begin
          unload  = 1'b1;
          data_d  = buf_data;
          valid_d = 1'b1;
          first_d = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (win_last) begin
          cnt_d = '0;
          if (buf_full) begin
            // Seamless reload: next window starts with no gap.
            unload  = 1'b1;
            data_d  = buf_data;
            valid_d = 1'b1;
            first_d = 1'b1;
          end else begin
            // Underflow set takes priority over a coincident clr_i.
            under_d = 1'b1;
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
`ifdef UPSAMPLE_HOLD_ZERO_STUFF_EN
          data_d = '0;
`else
          data_d = data_q;
`endif
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, counter and output registers; reset discards any partial window.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      first_q <= first_d;
      under_q <= under_d;
    end
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign first_o     = first_q;
  assign underflow_o = under_q;

endmodule

// File: tb/tb_upsample_hold.sv
// Self-checking bench for upsample_hold (DEC=20 main instance, DEC=1 side
// instance). A queue-and-countdown model predicts every output each cycle.
module tb_upsample_hold;

  localparam int unsigned OW  = 14;
  localparam int          DEC = 20;
`ifdef UPSAMPLE_HOLD_ZERO_STUFF_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_n = 1'b1;
  logic [OW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          ready_o, valid_o, first_o, underflow_o;
  logic [OW-1:0] data_o;

  logic [OW-1:0] d1_data_i = '0;
  logic          d1_valid_i = 1'b0;
  logic          d1_ready_o, d1_valid_o, d1_first_o, d1_under_o;
  logic [OW-1:0] d1_data_o;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;
  bit lb_on  = 1'b0;

  always #5 clk_i = ~clk_i;

  upsample_hold #(.OW(OW), .DEC(DEC)) u_dut (
    .clk_i(clk_i), .rst_n(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .clr_i(clr_i), .data_o(data_o), .valid_o(valid_o),
    .first_o(first_o), .underflow_o(underflow_o)
  );

  upsample_hold #(.OW(OW), .DEC(1)) u_dut1 (
    .clk_i(clk_i), .rst_n(rst_n), .data_i(d1_data_i), .valid_i(d1_valid_i),
    .ready_o(d1_ready_o), .clr_i(1'b0), .data_o(d1_data_o), .valid_o(d1_valid_o),
    .first_o(d1_first_o), .underflow_o(d1_under_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // pend: samples waiting; left: repetitions still to show of the current
  // sample, counting the one on the outputs now (0 = nothing showing).
  logic [OW-1:0] pend[$];
  int            left = 0;
  logic [OW-1:0] m_data = '0;
  bit            m_valid = 0, m_first = 0, m_under = 0;

  function automatic bit m_ready();
    return (pend.size() == 0) || (left <= 1);
  endfunction

  initial forever begin
    bit            acc;
    logic [OW-1:0] din;
    @(posedge clk_i or negedge rst_n);
    if (!rst_n) begin
      pend.delete();
      left = 0; m_data = '0; m_valid = 0; m_first = 0; m_under = 0;
    end else begin
      acc = valid_i && m_ready();
      din = data_i;
      if (clr_i) m_under = 0;
      if (pend.size() > 0 && left <= 1) begin
        m_data = pend.pop_front(); left = DEC; m_valid = 1; m_first = 1;
      end else if (left > 1) begin
        left--; m_first = 0;
        if (ZS) m_data = '0;
      end else if (left == 1) begin
        left = 0; m_valid = 0; m_first = 0; m_under = 1;
      end
      if (acc) pend.push_back(din);
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk_i);
    if (rst_n && chk_on) begin
      chk("valid_o", 32'(valid_o), 32'(m_valid));
      chk("first_o", 32'(first_o), 32'(m_first));
      chk("underflow_o", 32'(underflow_o), 32'(m_under));
      chk("ready_o", 32'(ready_o), 32'(m_ready()));
      chk("data_o", 32'(data_o), 32'(m_data));
    end
  end

  // Loopback: pick the first repetition of each window (a decimator) and
  // expect the original accepted sequence back.
  logic [OW-1:0] lb_q[$];
  initial forever begin
    @(negedge clk_i);
    if (lb_on && rst_n && valid_o && first_o) begin
      if (lb_q.size() == 0) chk("loopback_extra", 32'(data_o), 32'hFFFF_FFFF);
      else chk("loopback", 32'(data_o), 32'(lb_q.pop_front()));
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k, k1, gaps, gaps1, waited;
    logic [OW-1:0] q1[$];
    logic [OW-1:0] exp1;

    #2 rst_n = 1'b0;
    #1;
    chk("rst_data", 32'(data_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_first", 32'(first_o), 32'h0);
    chk("rst_under", 32'(underflow_o), 32'h0);
    repeat (3) @(negedge clk_i);
    rst_n = 1'b1;
    chk_on = 1'b1;
    @(negedge clk_i);
    chk("post_rst_ready", 32'(ready_o), 32'h1);

    // Single sample 0x123: 20 cycles, first only on cycle 1, then underflow.
    valid_i = 1'b1; data_i = 14'h123;
    @(negedge clk_i);
    valid_i = 1'b0;
    @(negedge clk_i);
    chk("s1_data", 32'(data_o), 32'h123);
    chk("s1_valid", 32'(valid_o), 32'h1);
    chk("s1_first", 32'(first_o), 32'h1);
    for (int i = 2; i <= 20; i++) begin
      @(negedge clk_i);
      chk("s1_run_valid", 32'(valid_o), 32'h1);
      chk("s1_run_first", 32'(first_o), 32'h0);
      chk("s1_run_data", 32'(data_o), ZS ? 32'h0 : 32'h123);
    end
    @(negedge clk_i);
    chk("s1_end_valid", 32'(valid_o), 32'h0);
    chk("s1_end_under", 32'(underflow_o), 32'h1);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    chk("s1_clr", 32'(underflow_o), 32'h0);

    // Async reset mid-window at cnt=7.
    valid_i = 1'b1; data_i = 14'h2AA;
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (8) @(posedge clk_i);
    #1;
    chk("mid_valid", 32'(valid_o), 32'h1);
    chk("mid_first", 32'(first_o), 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(data_o), 32'h0);
    chk("arst_valid", 32'(valid_o), 32'h0);
    chk("arst_first", 32'(first_o), 32'h0);
    chk("arst_ready", 32'(ready_o), 32'h1);
    @(negedge clk_i);
    rst_n = 1'b1;
    @(negedge clk_i);
    chk("arst_rel_valid", 32'(valid_o), 32'h0);
    chk("arst_rel_ready", 32'(ready_o), 32'h1);

    // Sustained ramp on DEC=20 with loopback, and on DEC=1 alongside.
    lb_on = 1'b1;
    k = 0; k1 = 0; gaps = 0; gaps1 = 0;
    for (int it = 0; it < 400; it++) begin
      @(negedge clk_i);
      if (it >= 2 && !d1_valid_o) gaps1++;
      if (d1_valid_o) begin
        exp1 = (q1.size() > 0) ? q1.pop_front() : '1;
        chk("dec1_data", 32'(d1_data_o), 32'(exp1));
        chk("dec1_first", 32'(d1_first_o), 32'h1);
      end
      if (it >= 2 && !valid_o) gaps++;
      valid_i = 1'b1; data_i = OW'(k);
      if (ready_o) begin lb_q.push_back(OW'(k)); k++; end
      d1_valid_i = 1'b1; d1_data_i = OW'(k1);
      if (d1_ready_o) begin q1.push_back(OW'(k1)); k1++; end
    end
    @(negedge clk_i);
    valid_i = 1'b0; d1_valid_i = 1'b0;
    chk("ramp_gaps", 32'(gaps), 32'h0);
    chk("dec1_gaps", 32'(gaps1), 32'h0);
    chk("ramp_under", 32'(underflow_o), 32'h0);
    chk("dec1_under", 32'(d1_under_o), 32'h0);

    // Drain to underflow (bounded).
    waited = 0;
    while (!underflow_o && waited < 100) begin @(negedge clk_i); waited++; end
    chk("drain_under", 32'(underflow_o), 32'h1);
    chk("lb_drained", 32'(lb_q.size()), 32'h0);
    lb_on = 1'b0;

    // Late producer: gap, clear, then resume one cycle after accept.
    repeat (2) @(negedge clk_i);
    chk("late_gap_valid", 32'(valid_o), 32'h0);
    clr_i = 1'b1;
    @(negedge clk_i);
    clr_i = 1'b0;
    chk("late_clr", 32'(underflow_o), 32'h0);
    valid_i = 1'b1; data_i = 14'h155;
    @(negedge clk_i);
    valid_i = 1'b0;
    chk("late_wait_valid", 32'(valid_o), 32'h0);
    @(negedge clk_i);
    chk("late_valid", 32'(valid_o), 32'h1);
    chk("late_data", 32'(data_o), 32'h155);
    chk("late_first", 32'(first_o), 32'h1);

    // Randomized traffic with varying producer duty and clear pulses.
    for (int seg = 0; seg < 12; seg++) begin
      int thr;
      thr = (seg % 4 == 0) ? 1 : (seg % 4 == 1) ? 3 : (seg % 4 == 2) ? 12 : 32;
      repeat (250) begin
        @(negedge clk_i);
        valid_i = ($urandom_range(0, 31) < thr);
        data_i  = OW'($urandom);
        clr_i   = ($urandom_range(0, 15) == 0);
      end
    end
    @(negedge clk_i);
    valid_i = 1'b0; clr_i = 1'b0;
    repeat (50) @(negedge clk_i);
    chk_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/upsample_hold.md
Name: upsample_hold

Overview:
- Inverse of the decimating downsample stage: takes a slow-rate sample stream and regenerates a full-rate stream at clk_i, emitting each input sample DEC times.
- Feeds full-rate consumers such as DAC or loopback paths, and lets the bench close the loop around downsample.
- Single clock domain. The slow stream arrives through a valid/ready handshake with a one-entry holding buffer.
- Flags underflow when the producer misses its slot.

Parameters:
- OW, 14: sample width (signed two's complement, passed through unmodified).
- DEC, 20: repetition factor; legal range 1..1024.
- CW, $clog2(DEC) (minimum 1): repetition counter width; derived, not overridden.

Ports:
- clk_i, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous assert, active-low.
- data_i, input, OW: slow-rate input sample.
- valid_i, input, 1: data_i valid.
- ready_o, output, 1: buffer can accept this cycle.
- clr_i, input, 1: synchronous clear of underflow_o.
- data_o, output, OW: full-rate output sample.
- valid_o, output, 1: data_o valid this cycle.
- first_o, output, 1: high on the first of the DEC repetitions.
- underflow_o, output, 1: sticky; set when a repetition window ends with no next sample buffered.

Behaviour:
- Reset (async, rst_n=0):
  - data_o=0, valid_o=0, first_o=0, underflow_o=0.
  - Buffer empty, cnt=0, state=IDLE.
  - Applies at any time, including mid-window; the partially emitted sample is discarded.
- Buffer:
  - One OW-bit register buf plus buf_full.
  - Accept when valid_i && ready_o; the sample is written at that edge.
- Unload:
  - unload = buf_full && (state==IDLE || (state==RUN && cnt==DEC-1)).
  - ready_o = !buf_full || unload. This is a function of registers only, with no combinational path from valid_i.
  - Simultaneous accept and unload in one cycle: buf takes the new sample and buf_full stays 1.
- States:
  - IDLE: valid_o=0, first_o=0, data_o holds its last value.
    - On unload: data_o<=buf, valid_o<=1, first_o<=1, cnt<=0, go to RUN.
  - RUN: valid_o=1, cnt increments each edge, first_o=1 only when cnt==0.
    - At cnt==DEC-1 with buf_full: reload data_o, cnt<=0, first_o<=1, stay in RUN (seamless, no gap).
    - At cnt==DEC-1 with buf empty: underflow_o<=1, valid_o<=0, go to IDLE.
- Latency: sample accepted at edge N appears on data_o with valid_o=1 after edge N+1 when IDLE. When RUN, it appears at the edge following the current window's last cycle.
- Sustained throughput: one input per DEC cycles, with no underflow when the producer presents valid_i at least one cycle before the window ends.
- DEC=1: each sample is output once; back-to-back accepts sustain valid_o=1 continuously.
- underflow_o:
  - Cleared by clr_i at the next edge.
  - If clr_i and an underflow event coincide, the set wins.
- cnt wraps only via the reload or IDLE transitions; it never exceeds DEC-1.

Optional Feature:
- Macro: UPSAMPLE_HOLD_ZERO_STUFF_EN.
- Defined: zero-stuffing interpolator front end. data_o equals the sample only when first_o=1; the other DEC-1 cycles output 0 with valid_o=1. Timing, handshake and underflow behaviour are unchanged.
- Undefined: zero-order hold; data_o carries the sample for all DEC cycles.

Decomposition:
- Shared package/defines (fmcw_defines.vh): OW default, DEC default, and a localparam macro for CW.
- State encoding localparams (IDLE=1'b0, RUN=1'b1) stay local to the module.
- One natural sub-module: upsample_hold_buf, the one-entry valid/ready holding register with simultaneous load/unload. Reusable by other stream stages.

Test Plan:
- Reset: rst_n=0 asserted mid-RUN at cnt=7 -> all outputs 0 immediately (async); after release, ready_o=1 and valid_o=0.
- Single sample, DEC=20: data_i=0x123 accepted at edge N -> data_o=0x123 with valid_o=1 for exactly 20 cycles from edge N+1. first_o is high for cycle 1 only. Then valid_o=0 and underflow_o=1.
- Sustained ramp, DEC=20: producer offers 0,1,2,... each time ready_o is high -> valid_o continuously 1, each value repeated 20x, first_o every 20 cycles, underflow_o stays 0.
- Late producer: next sample offered 3 cycles after the window ends -> valid_o low for the gap and underflow_o set. clr_i pulse clears it. Output resumes 1 cycle after accept.
- Loopback: upsample_hold(DEC=20) output fed into downsample -> downsample output equals the original input sequence.
- UPSAMPLE_HOLD_ZERO_STUFF_EN defined, input 5 -> data_o sequence is 5 followed by 19 zeros, all with valid_o=1.
